// File: rtl/and_if_pkg.sv
// Shared defaults and operand type for the registered bitwise-AND stream unit.
package and_if_pkg;
  localparam int AND_IF_WIDTH = 4;
  localparam int AND_IF_CNT_W = 16;
  typedef logic [AND_IF_WIDTH-1:0] operand_t;
endpackage

// File: rtl/and_if_skid.sv
// Single-entry skid register: output stage plus one spill entry, strict FIFO order.
// Latency 1 cycle; i_rdy only reaches o_rdy through a register (o_rdy = spill entry empty).
module and_if_skid
  import and_if_pkg::*;
#(
  parameter int WIDTH = AND_IF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_dat;
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_skid_dat;
  logic             w_in_xfer;
  logic             w_out_free;

  assign w_in_xfer  = i_vld & ~r_skid_vld;
  assign w_out_free = ~r_out_vld | i_rdy;

  // Output stage refills from the spill entry first; the spill entry only fills
  // while the output stage is stalled, so a full spill never has an empty output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_skid_vld <= 1'b0;
      r_skid_dat <= '0;
    end else if (w_out_free) begin
      if (r_skid_vld) begin
        r_out_vld  <= 1'b1;
        r_out_dat  <= r_skid_dat;
        r_skid_vld <= 1'b0;
        r_skid_dat <= '0;
      end else if (w_in_xfer) begin
        r_out_vld <= 1'b1;
        r_out_dat <= i_dat;
      end else begin
        r_out_vld <= 1'b0;
        r_out_dat <= '0;
      end
    end else if (w_in_xfer) begin
      r_skid_vld <= 1'b1;
      r_skid_dat <= i_dat;
    end
  end

  assign o_rdy = ~r_skid_vld;
  assign o_vld = r_out_vld;
  assign o_dat = r_out_dat;

endmodule

// File: rtl/and_if_unit.sv
// Registered a & b with valid/ready on both sides and a delivered-result counter.
// Optional zero flag on y when AND_IF_UNIT_ZERO_FLAG_EN is defined.
module and_if_unit
  import and_if_pkg::*;
#(
  parameter int WIDTH = AND_IF_WIDTH,
  parameter int CNT_W = AND_IF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
`ifdef AND_IF_UNIT_ZERO_FLAG_EN
  output logic             y_zero,
`endif
  output logic [CNT_W-1:0] txn_count
);

`ifdef AND_IF_UNIT_ZERO_FLAG_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  logic [WIDTH-1:0] w_and;
  logic [SW-1:0]    w_skid_in;
  logic [SW-1:0]    w_skid_out;
  logic [CNT_W-1:0] r_txn_count;

  assign w_and = a & b;

  // The zero flag rides through the skid with its data so it stays aligned under stall.
`ifdef AND_IF_UNIT_ZERO_FLAG_EN
  assign w_skid_in = {(w_and == '0), w_and};
  assign y_zero    = w_skid_out[WIDTH];
`else
  assign w_skid_in = w_and;
`endif
  assign y = w_skid_out[WIDTH-1:0];

  and_if_skid #(.WIDTH(SW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .i_vld (in_valid),
    .o_rdy (in_ready),
    .i_dat (w_skid_in),
    .o_vld (out_valid),
    .i_rdy (out_ready),
    .o_dat (w_skid_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txn_count <= '0;
    end else if (out_valid && out_ready) begin
      r_txn_count <= r_txn_count + CNT_W'(1);
    end
  end

  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_and_if_unit.sv
// Directed and random stream traffic against a queue-based reference model.
module tb_and_if_unit;
  import and_if_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  operand_t   a;
  operand_t   b;
  logic       in_ready;
  logic       out_valid;
  operand_t   y;
  logic [15:0] txn_count;
  logic       in_ready2;
  logic       out_valid2;
  operand_t   y2;
  logic [1:0] txn_count2;
`ifdef AND_IF_UNIT_ZERO_FLAG_EN
  logic       y_zero;
  logic       y_zero2;
`endif

  int n_total = 0;
  int n_pass  = 0;
  operand_t q[$];
  int delivered = 0;

  and_if_unit #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
`ifdef AND_IF_UNIT_ZERO_FLAG_EN
    .y_zero(y_zero),
`endif
    .txn_count(txn_count)
  );

  and_if_unit #(.WIDTH(4), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
`ifdef AND_IF_UNIT_ZERO_FLAG_EN
    .y_zero(y_zero2),
`endif
    .txn_count(txn_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic     exp_vld;
    operand_t exp_y;
    exp_vld = (q.size() > 0);
    exp_y   = exp_vld ? q[0] : '0;
    chk("in_ready",   32'(in_ready),   32'(q.size() < 2));
    chk("out_valid",  32'(out_valid),  32'(exp_vld));
    chk("y",          32'(y),          32'(exp_y));
    chk("txn_count",  32'(txn_count),  32'(delivered % 65536));
    chk("txn_count2", 32'(txn_count2), 32'(delivered % 4));
    chk("y2",         32'(y2),         32'(exp_y));
`ifdef AND_IF_UNIT_ZERO_FLAG_EN
    chk("y_zero",     32'(y_zero),     32'(exp_vld && exp_y == 4'h0));
    chk("y_zero2",    32'(y_zero2),    32'(exp_vld && exp_y == 4'h0));
`endif
  endtask

  // Check outputs, drive one cycle of stimulus, then advance the model across the edge.
  task automatic cycle(input logic v, input operand_t av, input operand_t bv, input logic ordy);
    logic rdy_now;
    logic vld_now;
    @(negedge clk);
    check_all();
    in_valid  = v;
    a         = av;
    b         = bv;
    out_ready = ordy;
    rdy_now = (q.size() < 2);
    vld_now = (q.size() > 0);
    @(posedge clk);
    if (vld_now && ordy) begin
      void'(q.pop_front());
      delivered++;
    end
    if (v && rdy_now) q.push_back(av & bv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 4'hF;
    b         = 4'hF;
    out_ready = 1'b0;
    @(posedge clk);
    q.delete();
    delivered = 0;
    @(negedge clk);
    check_all();
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    do_reset();

    // Basic
    cycle(1'b1, 4'b0100, 4'b1100, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);

    // Streaming back-to-back
    cycle(1'b1, 4'hF, 4'hA, 1'b1);
    cycle(1'b1, 4'h3, 4'h5, 1'b1);
    cycle(1'b1, 4'h0, 4'hF, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);

    // Backpressure fills output and skid, then drains in order
    cycle(1'b1, 4'hF, 4'h9, 1'b0);
    cycle(1'b1, 4'h6, 4'h7, 1'b0);
    cycle(1'b1, 4'hE, 4'hE, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);

    // Reset mid-operation with both entries full
    cycle(1'b1, 4'hF, 4'hF, 1'b0);
    cycle(1'b1, 4'h3, 4'h3, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, 1'b0);
    do_reset();
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);

    // Zero-result patterns, also walks the 2-bit counter past its wrap
    cycle(1'b1, 4'b1010, 4'b0101, 1'b1);
    cycle(1'b1, 4'b1010, 4'b0010, 1'b1);
    cycle(1'b1, 4'h7, 4'h1, 1'b1);
    cycle(1'b1, 4'h8, 4'h8, 1'b1);
    cycle(1'b1, 4'hC, 4'h4, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 4'h0, 1'b1);

    @(negedge clk);
    check_all();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
